// File: rtl/sqe.sv
// Box-counting quad expander: reads each coarse BC cell and writes its count to the
// four covering fine cells, either replicated or split so the four values sum to it.
module sqe #(
    parameter int BOX_IDX = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 split_mode,
    input  logic [7:0]           x,
    output logic                 busy,
    output logic                 done,
    output logic                 wen_sqe,
    output logic [7:0]           y,
    output logic [2*BOX_IDX+1:0] BC_rd_addr,
    output logic [2*BOX_IDX+1:0] BC_wr_addr
);
    localparam int CW = BOX_IDX - 1;
    localparam int AW = 2 * BOX_IDX + 2;

    typedef enum logic [2:0] {IDLE, RD, CAP, W0, W1, W2, W3, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic            split_q, split_d;
    logic [7:0]      xr_q, xr_d;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [7:0]      y_q, y_d;
    logic [1:0]      quad;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            split_q <= 1'b0;
            xr_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            split_q <= split_d;
            xr_q    <= xr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        split_d = split_q;
        xr_d    = xr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        y_d     = y_q;
        busy    = 1'b0;
        done    = 1'b0;
        wen_sqe = 1'b0;
        quad    = 2'd0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RD;
                cx_d    = '0;
                cy_d    = '0;
                split_d = split_mode;
            end
            RD: begin
                busy    = 1'b1;
                rd_d    = {1'b0, 1'b0, cx_q, 1'b0, 1'b0, cy_q};
                state_d = CAP;
            end
            CAP: begin
                busy    = 1'b1;
                xr_d    = x;
                state_d = W0;
            end
            W0: begin busy = 1'b1; wen_sqe = 1'b1; quad = 2'd0; state_d = W1; end
            W1: begin busy = 1'b1; wen_sqe = 1'b1; quad = 2'd1; state_d = W2; end
            W2: begin busy = 1'b1; wen_sqe = 1'b1; quad = 2'd2; state_d = W3; end
            W3: begin
                busy    = 1'b1;
                wen_sqe = 1'b1;
                quad    = 2'd3;
                cx_d    = cx_q + CW'(1);
                if (&cx_q) cy_d = cy_q + CW'(1);
                state_d = (&cx_q && &cy_q) ? DONE : RD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Split remainder lands on the lowest quadrants so the four writes sum to x_r.
        if (wen_sqe) begin
            wr_d = {1'b0, cx_q, quad[0], 1'b0, cy_q, quad[1]};
            y_d  = split_q ? (xr_q >> 2) + {7'b0, (quad < xr_q[1:0])} : xr_q;
        end
    end

    // Addresses and data show the current value while in use and hold it otherwise.
    assign BC_rd_addr = rd_d;
    assign BC_wr_addr = wr_d;
    assign y          = y_d;

endmodule

// File: tb/tb_sqe.sv
// Directed bench for sqe: BC memory model, write scoreboard, timing and boundary checks.
module tb_sqe;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       split_mode = 1'b0;
    logic [7:0] x = 8'h00;
    logic       busy, done, wen_sqe;
    logic [7:0] y, BC_rd_addr, BC_wr_addr;

    sqe #(.BOX_IDX(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .split_mode(split_mode), .x(x),
        .busy(busy), .done(done), .wen_sqe(wen_sqe), .y(y),
        .BC_rd_addr(BC_rd_addr), .BC_wr_addr(BC_wr_addr)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  mem [0:255];
    always @(posedge CLK) x <= mem[BC_rd_addr];

    int          checks = 0;
    int          errs = 0;
    int          nwr;
    int          d;
    logic [15:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected fine writes in scan order; split uses ceil-style division per quadrant.
    task automatic push_run(input bit sm);
        for (int cy = 0; cy < 4; cy++)
            for (int cx = 0; cx < 4; cx++)
                for (int q = 0; q < 4; q++) begin
                    int c, fx, fy, v;
                    c  = int'(mem[cx*16 + cy]);
                    fx = 2*cx + (q % 2);
                    fy = 2*cy + (q / 2);
                    v  = sm ? (c + 3 - q) / 4 : c;
                    sb.push_back({8'(fx*16 + fy), 8'(v)});
                end
    endtask

    task automatic run(input int max, input int pa, input int pb, input int tog,
                       input int abort_at, output int done_at);
        done_at = -1;
        nwr = 0;
        start = 1'b1;
        for (int k = 1; k <= max; k++) begin
            @(negedge CLK);
            start = (k == pa || k == pb);
            if (k == tog) split_mode = ~split_mode;
            if (k == 1) chk("busy_in_rd", 32'(busy), 1);
            if (wen_sqe) begin
                nwr++;
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("wr_addr_data", {16'h0, BC_wr_addr, y}, {16'h0, sb.pop_front()});
            end
            if (k == 43) chk("rd_addr_cell31", 32'(BC_rd_addr), 32'h31);
            if (k == 44) chk("rd_addr_hold", 32'(BC_rd_addr), 32'h31);
            if (done) begin
                done_at = k;
                break;
            end
            if (k == abort_at) begin
                RST_N = 1'b0;
                #1;
                chk("abort_outs", {24'h0, busy, done, wen_sqe, 5'h0}, 0);
                chk("abort_y", 32'(y), 0);
                chk("abort_addr", {16'h0, BC_rd_addr, BC_wr_addr}, 0);
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #1;
        chk("rst_ctrl", {29'h0, busy, done, wen_sqe}, 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_addr", {16'h0, BC_rd_addr, BC_wr_addr}, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Replicate run, coarse(i) = i+1
        for (int cy = 0; cy < 4; cy++)
            for (int cx = 0; cx < 4; cx++) mem[cx*16 + cy] = 8'(cy*4 + cx + 1);
        split_mode = 1'b0;
        push_run(0);
        run(200, -1, -1, -1, -1, d);
        chk("rep_done_cycle", d, 97);
        chk("rep_nwr", nwr, 64);
        chk("rep_sb_drained", sb.size(), 0);

        // start during DONE is ignored
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("start_in_done_busy", 32'(busy), 0);
        @(negedge CLK);
        chk("start_in_done_still_idle", 32'(busy), 0);

        // Split run with boundary counts in the first cells
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'd7; mem[16] = 8'd255; mem[32] = 8'd2; mem[48] = 8'd0;
        split_mode = 1'b1;
        push_run(1);
        run(200, -1, -1, -1, -1, d);
        chk("split_done_cycle", d, 97);
        chk("split_nwr", nwr, 64);
        chk("split_sb_drained", sb.size(), 0);
        @(negedge CLK);

        // start pulses while busy are ignored
        split_mode = 1'b0;
        push_run(0);
        run(200, 10, 50, -1, -1, d);
        chk("pulse_done_cycle", d, 97);
        chk("pulse_nwr", nwr, 64);

        // start in cycle after done; split_mode toggled mid-run keeps latched mode
        @(negedge CLK);
        chk("after_done_idle", {30'h0, done, wen_sqe}, 0);
        push_run(0);
        run(200, -1, -1, 20, -1, d);
        chk("b2b_done_cycle", d, 97);
        chk("b2b_nwr", nwr, 64);
        chk("b2b_sb_drained", sb.size(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("no_extra_done", {30'h0, done, wen_sqe}, 0);
        end

        // Reset during W1 of cell 5, then restart from cell 0
        split_mode = 1'b1;
        push_run(1);
        run(200, -1, -1, -1, 34, d);
        chk("abort_no_done", d, -1);
        chk("abort_nwr", nwr, 22);
        chk("abort_sb_left", sb.size(), 42);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("in_reset_quiet", {29'h0, busy, done, wen_sqe}, 0);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        push_run(1);
        run(200, -1, -1, -1, -1, d);
        chk("restart_done_cycle", d, 97);
        chk("restart_nwr", nwr, 64);
        chk("restart_sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
